tpu_stage_sequencer: RTL and testbench

TPU_STAGE_SEQUENCER -- requirements
Module: tpu_stage_sequencer

---
 rtl/tpu_stage_sequencer_pkg.sv | 40 ++++
 rtl/tpu_stage_sequencer_watchdog.sv | 29 ++
 rtl/tpu_stage_sequencer.sv | 161 ++++++++++++++++
 tb/tb_tpu_stage_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_stage_sequencer_pkg.sv
// TPU stage sequencer shared defines: state encoding, stage indices,
// and the stage-skip helper used on start accept and on stage completion.
package tpu_stage_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MATMUL = 3'd1,
      ST_NORM   = 3'd2,
      ST_POOL   = 3'd3,
      ST_ACT    = 3'd4,
      ST_DONE   = 3'd5
   } seq_state_t;

   localparam int STG_MATMUL = 0;
   localparam int STG_NORM   = 1;
   localparam int STG_POOL   = 2;
   localparam int STG_ACT    = 3;
   localparam int NUM_STAGES = 4;

   // Lowest enabled stage at or after index 'from'; DONE when none remain.
   function automatic seq_state_t first_enabled(
      input logic [NUM_STAGES-1:0] en,
      input int                    from
   );
      seq_state_t s;
      s = ST_DONE;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (i >= from && en[i]) begin
            s = seq_state_t'(3'(i + 1));
         end
      end
      return s;
   endfunction

   function automatic logic is_stage(input seq_state_t s);
      return (s == ST_MATMUL) || (s == ST_NORM) ||
             (s == ST_POOL)   || (s == ST_ACT);
   endfunction

endpackage

// File: rtl/tpu_stage_sequencer_watchdog.sv
// Per-stage cycle counter for the sequencer watchdog (built with
// SEQ_TIMEOUT_EN); the count is 0 on a stage's start-pulse cycle.
module seq_watchdog #(
   parameter int LIMIT = 4096
) (
   input  logic clk,
   input  logic resetn,
   input  logic in_stage,
   input  logic restart,
   output logic expired
);

   localparam int CW = $clog2(LIMIT) + 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_eff;

   assign cnt_eff = restart ? '0 : cnt_q;
   assign expired = in_stage && (cnt_eff == CW'(LIMIT - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= in_stage ? cnt_eff + 1'b1 : '0;
      end
   end

endmodule

// File: rtl/tpu_stage_sequencer.sv
// Runs the enabled TPU stages in fixed order MATMUL, NORM, POOL, ACT.
// Define SEQ_TIMEOUT_EN to add the per-stage watchdog and timeout_err.
module tpu_stage_sequencer
   import tpu_stage_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic resetn,
   input  logic start_tpu,
   input  logic enable_matmul,
   input  logic enable_norm,
   input  logic enable_pool,
   input  logic enable_activation,
   input  logic matmul_done,
   input  logic norm_done,
   input  logic pool_done,
   input  logic activation_done,
   output logic start_matmul,
   output logic start_norm,
   output logic start_pool,
   output logic start_activation,
   output logic done_tpu,
   output logic busy,
   output logic timeout_err
);

   seq_state_t state;
   seq_state_t nxt;
   seq_state_t stage_nxt;

   logic [NUM_STAGES-1:0] en_in;
   logic [NUM_STAGES-1:0] en_q;

   logic start_q;
   logic armed;
   logic accept;
   logic busy_r;
   logic in_stage;
   logic cur_done;
   logic cur_pulse;
   logic done_ok;
   logic wd_exp;

   assign en_in = {enable_activation, enable_pool,
                   enable_norm, enable_matmul};

   assign cur_pulse = start_matmul | start_norm |
                      start_pool | start_activation;

   // A done on the pulse cycle belongs to nothing yet.
   assign done_ok = in_stage & cur_done & ~cur_pulse;

   assign busy = busy_r | accept;

   always_comb begin
      in_stage  = 1'b0;
      cur_done  = 1'b0;
      stage_nxt = ST_DONE;
      case (state)
         ST_MATMUL: begin
            in_stage  = 1'b1;
            cur_done  = matmul_done;
            stage_nxt = first_enabled(en_q, STG_NORM);
         end
         ST_NORM: begin
            in_stage  = 1'b1;
            cur_done  = norm_done;
            stage_nxt = first_enabled(en_q, STG_POOL);
         end
         ST_POOL: begin
            in_stage  = 1'b1;
            cur_done  = pool_done;
            stage_nxt = first_enabled(en_q, STG_ACT);
         end
         ST_ACT: begin
            in_stage  = 1'b1;
            cur_done  = activation_done;
            stage_nxt = ST_DONE;
         end
         default: ;
      endcase
   end

   always_comb begin
      nxt    = state;
      accept = 1'b0;
      if (in_stage) begin
         if (done_ok) begin
            nxt = stage_nxt;
         end else if (wd_exp) begin
            nxt = ST_DONE;
         end
      end else if (state == ST_DONE) begin
         nxt = start_tpu ? ST_DONE : ST_IDLE;
      end else begin
         // IDLE and any undefined encoding
         accept = armed & start_tpu & ~start_q;
         nxt    = accept ? first_enabled(en_in, STG_MATMUL) : ST_IDLE;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   seq_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wd (
      .clk      (clk),
      .resetn   (resetn),
      .in_stage (in_stage),
      .restart  (cur_pulse),
      .expired  (wd_exp)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timeout_err <= 1'b0;
      end else if (accept) begin
         timeout_err <= 1'b0;
      end else if (in_stage && !done_ok && wd_exp) begin
         timeout_err <= 1'b1;
      end
   end
`else
   assign wd_exp      = 1'b0;
   assign timeout_err = 1'b0;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_limit
      $error("TIMEOUT_CYCLES must be at least 2");
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state            <= ST_IDLE;
         start_q          <= 1'b0;
         armed            <= 1'b0;
         en_q             <= '0;
         busy_r           <= 1'b0;
         done_tpu         <= 1'b0;
         start_matmul     <= 1'b0;
         start_norm       <= 1'b0;
         start_pool       <= 1'b0;
         start_activation <= 1'b0;
      end else begin
         state   <= nxt;
         start_q <= start_tpu;
         // start must be seen low after reset before an edge counts
         armed   <= armed | ~start_tpu;
         if (accept) begin
            en_q <= en_in;
         end
         busy_r           <= is_stage(nxt);
         done_tpu         <= (nxt == ST_DONE);
         start_matmul     <= (nxt == ST_MATMUL) && (state != ST_MATMUL);
         start_norm       <= (nxt == ST_NORM)   && (state != ST_NORM);
         start_pool       <= (nxt == ST_POOL)   && (state != ST_POOL);
         start_activation <= (nxt == ST_ACT)    && (state != ST_ACT);
      end
   end

endmodule

// File: tb/tb_tpu_stage_sequencer.sv
// Directed bench for tpu_stage_sequencer: expected stage pulses are queued
// at stimulus time and matched as the DUT emits them; done is auto-returned.
module tb_tpu_stage_sequencer;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic start_tpu = 1'b0;
   logic [3:0] en = 4'h0;
   logic [3:0] man_done = 4'h0;
   logic [3:0] resp_done = 4'h0;

   logic start_matmul, start_norm, start_pool, start_activation;
   logic done_tpu, busy, timeout_err;

   tpu_stage_sequencer #(
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .start_tpu         (start_tpu),
      .enable_matmul     (en[0]),
      .enable_norm       (en[1]),
      .enable_pool       (en[2]),
      .enable_activation (en[3]),
      .matmul_done       (resp_done[0] | man_done[0]),
      .norm_done         (resp_done[1] | man_done[1]),
      .pool_done         (resp_done[2] | man_done[2]),
      .activation_done   (resp_done[3] | man_done[3]),
      .start_matmul      (start_matmul),
      .start_norm        (start_norm),
      .start_pool        (start_pool),
      .start_activation  (start_activation),
      .done_tpu          (done_tpu),
      .busy              (busy),
      .timeout_err       (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int stage;
      int gap;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   int ref_cyc = 0;
   int pulse_cyc[4];
   int cnt[4];
   bit resp_en = 1'b0;
   int resp_dly = 3;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int s, input int g);
      exp_t e;
      e.stage = s;
      e.gap   = g;
      sb.push_back(e);
   endtask

   task automatic raise(input logic [3:0] e);
      en        = e;
      start_tpu = 1'b1;
      ref_cyc   = cyc;
   endtask

   task automatic wait_done(input int lim);
      int n;
      n = 0;
      while (!done_tpu && n < lim) begin
         tick();
         n++;
      end
      chk("done_wait", int'(done_tpu), 1);
   endtask

   task automatic finish_run();
      start_tpu = 1'b0;
      tick(2);
      chk("idle_after_done", int'(done_tpu), 0);
   endtask

   // Pulse monitor, scoreboard pop, and done responder.
   always @(negedge clk) begin
      logic [3:0] p;
      int s;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         resp_done[i] = 1'b0;
         if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) resp_done[i] = 1'b1;
         end
      end
      p = {start_activation, start_pool, start_norm, start_matmul};
      if (p != 4'h0) begin
         s = 0;
         for (int i = 0; i < 4; i++) if (p[i]) s = i;
         chk("pulse_onehot", $countones(p), 1);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", int'(p), 0);
         end else begin
            e = sb.pop_front();
            chk("pulse_stage", s, e.stage);
            chk("pulse_gap", cyc - ref_cyc, e.gap);
         end
         ref_cyc      = cyc;
         pulse_cyc[s] = cyc;
         if (resp_en) cnt[s] = resp_dly;
      end
   end

   initial begin
      int n;
      // reset with start already high: must not launch afterwards
      resetn    = 1'b0;
      start_tpu = 1'b1;
      tick(2);
      chk("rst_done", int'(done_tpu), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_tmo", int'(timeout_err), 0);
      chk("rst_pulses", int'({start_activation, start_pool,
                              start_norm, start_matmul}), 0);
      resetn = 1'b1;
      tick(5);
      chk("no_start_after_reset", int'(busy), 0);
      start_tpu = 1'b0;
      tick(2);

      // all stages, done 3 cycles after each pulse
      resp_en = 1'b1;
      push(0, 1); push(1, 4); push(2, 4); push(3, 4);
      raise(4'hF);
      tick(2);
      chk("busy_run", int'(busy), 1);
      wait_done(60);
      chk("done_lat_all", cyc - pulse_cyc[3], 4);
      chk("busy_in_done", int'(busy), 0);
      chk("sb_empty_all", sb.size(), 0);
      tick(3);
      chk("done_hold", int'(done_tpu), 1);
      chk("tmo_clear_run", int'(timeout_err), 0);
      finish_run();

      // norm + act only
      push(1, 1); push(3, 4);
      raise(4'b1010);
      wait_done(40);
      chk("done_lat_na", cyc - pulse_cyc[3], 4);
      chk("sb_empty_na", sb.size(), 0);
      finish_run();

      // nothing enabled
      raise(4'h0);
      #1;
      chk("busy_empty_accept", int'(busy), 1);
      chk("done_empty_pre", int'(done_tpu), 0);
      tick();
      chk("done_empty", int'(done_tpu), 1);
      chk("busy_empty_after", int'(busy), 0);
      finish_run();

      // enables dropped mid-run are ignored
      push(0, 1); push(1, 4); push(2, 4); push(3, 4);
      raise(4'hF);
      tick(2);
      en = 4'b1001;
      wait_done(60);
      chk("sb_empty_latch", sb.size(), 0);
      finish_run();

      // reset pulse during NORM, start held high
      push(0, 1); push(1, 4);
      raise(4'hF);
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      chk("reach_norm", sb.size(), 0);
      tick();
      resetn = 1'b0;
      #1;
      chk("midrst_done", int'(done_tpu), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_norm", int'(start_norm), 0);
      tick();
      resetn = 1'b1;
      tick(15);
      chk("midrst_idle_busy", int'(busy), 0);
      chk("midrst_idle_done", int'(done_tpu), 0);
      start_tpu = 1'b0;
      tick(2);

      // early done on pulse cycle and foreign dones ignored
      resp_en = 1'b0;
      push(0, 1);
      raise(4'b0001);
      tick();
      chk("mm_pulse", int'(start_matmul), 1);
      man_done = 4'b0011;
      tick();
      man_done = 4'h0;
      tick(2);
      chk("early_done_ignored", int'(done_tpu), 0);
      chk("early_busy", int'(busy), 1);
      man_done = 4'b1110;
      tick();
      man_done = 4'h0;
      tick();
      chk("foreign_done_ignored", int'(done_tpu), 0);
      man_done = 4'b0001;
      tick();
      man_done = 4'h0;
      chk("mm_done_accepted", int'(done_tpu), 1);
      finish_run();

`ifdef SEQ_TIMEOUT_EN
      // matmul never completes
      push(0, 1);
      raise(4'b0001);
      wait_done(40);
      chk("tmo_lat", cyc - pulse_cyc[0], 16);
      chk("tmo_set", int'(timeout_err), 1);
      start_tpu = 1'b0;
      tick(2);
      chk("tmo_sticky", int'(timeout_err), 1);
      raise(4'h0);
      tick();
      chk("tmo_cleared", int'(timeout_err), 0);
      finish_run();
`endif

      tick(4);
      chk("sb_final", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
